// File: rtl/pe_pkg.sv
// Shared mode constants and the signed accumulator adder for the PE.
// Build option PE_MAC_SAT_EN: clamp on overflow instead of two's-complement wrap.
package pe_pkg;

   localparam logic PE_MODE_WS = 1'b0;
   localparam logic PE_MODE_OS = 1'b1;

   // Sums are computed at 64 bits, so callers must keep acc_w <= 63.
   localparam int PE_SUM_W = 64;

   typedef struct packed {
      logic                ovf;
      logic [PE_SUM_W-1:0] sum;
   } pe_add_t;

   // Signed addition of two values that already fit in acc_w bits.
   function automatic pe_add_t sat_add(input logic signed [PE_SUM_W-1:0] a,
                                       input logic signed [PE_SUM_W-1:0] b,
                                       input int acc_w);
      logic signed [PE_SUM_W-1:0] full;
      logic signed [PE_SUM_W-1:0] max_v;
      logic signed [PE_SUM_W-1:0] min_v;
`ifndef PE_MAC_SAT_EN
      logic signed [PE_SUM_W-1:0] wrap;
`endif
      pe_add_t r;
      max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      full  = a + b;
      r.ovf = (full > max_v) || (full < min_v);
`ifdef PE_MAC_SAT_EN
      r.sum = r.ovf ? ((full > max_v) ? max_v : min_v) : full;
`else
      wrap  = full <<< (PE_SUM_W - acc_w);
      wrap  = wrap >>> (PE_SUM_W - acc_w);
      r.sum = wrap;
`endif
      return r;
   endfunction

endpackage

// File: rtl/pe_mac_sys_if.sv
// Operand, forwarding and result bundle of one systolic PE.
interface pe_mac_sys_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
);
   logic                     mode;
   logic signed [DATA_W-1:0] w_in;
   logic                     w_load;
   logic signed [DATA_W-1:0] w_out;
   logic signed [DATA_W-1:0] x_in;
   logic                     x_valid_in;
   logic signed [DATA_W-1:0] x_out;
   logic                     x_valid_out;
   logic signed [ACC_W-1:0]  acc_in;
   logic                     drain;
   logic signed [ACC_W-1:0]  res;
   logic                     res_valid;
   logic                     ovf;

   modport master (
      output mode, w_in, w_load, x_in, x_valid_in, acc_in, drain,
      input  w_out, x_out, x_valid_out, res, res_valid, ovf
   );

   modport slave (
      input  mode, w_in, w_load, x_in, x_valid_in, acc_in, drain,
      output w_out, x_out, x_valid_out, res, res_valid, ovf
   );
endinterface

// File: rtl/pe_mac_sys_mul_pipe.sv
// Signed DATA_W x DATA_W multiplier with MUL_LAT register stages carrying
// valid, mode and an ACC_W-bit sideband alongside the product.
module pe_mul_pipe
   import pe_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 40,
   parameter int MUL_LAT = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       valid_i,
   input  logic                       mode_i,
   input  logic signed [DATA_W-1:0]   a_i,
   input  logic signed [DATA_W-1:0]   b_i,
   input  logic signed [ACC_W-1:0]    side_i,
   output logic                       valid_o,
   output logic                       mode_o,
   output logic signed [2*DATA_W-1:0] prod_o,
   output logic signed [ACC_W-1:0]    side_o
);
   localparam int PW = 2 * DATA_W;

   logic                 vld_q  [MUL_LAT];
   logic                 mode_q [MUL_LAT];
   logic signed [PW-1:0] prod_q [MUL_LAT];
   logic signed [ACC_W-1:0] side_q [MUL_LAT];
   logic signed [PW-1:0] prod_d;

   assign prod_d = PW'(a_i) * PW'(b_i);

   for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q[gi]  <= 1'b0;
               mode_q[gi] <= PE_MODE_WS;
               prod_q[gi] <= '0;
               side_q[gi] <= '0;
            end else if (en) begin
               vld_q[gi]  <= valid_i;
               mode_q[gi] <= mode_i;
               prod_q[gi] <= prod_d;
               side_q[gi] <= side_i;
            end
         end
      end else begin : g_tail
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q[gi]  <= 1'b0;
               mode_q[gi] <= PE_MODE_WS;
               prod_q[gi] <= '0;
               side_q[gi] <= '0;
            end else if (en) begin
               vld_q[gi]  <= vld_q[gi-1];
               mode_q[gi] <= mode_q[gi-1];
               prod_q[gi] <= prod_q[gi-1];
               side_q[gi] <= side_q[gi-1];
            end
         end
      end
   end

   assign valid_o = vld_q[MUL_LAT-1];
   assign mode_o  = mode_q[MUL_LAT-1];
   assign prod_o  = prod_q[MUL_LAT-1];
   assign side_o  = side_q[MUL_LAT-1];
endmodule

// File: rtl/pe_mac_sys.sv
// Systolic PE: pipelined signed MAC, weight-stationary or output-stationary per operand.
// Build option PE_MAC_SAT_EN selects saturating instead of wrapping accumulation.
module pe_mac_sys
   import pe_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 40,
   parameter int MUL_LAT = 2
) (
   input logic        clk,
   input logic        rst_n,
   input logic        en,
   pe_mac_sys_if.slave bus
);
   logic signed [DATA_W-1:0]   w_stat_q, w_stat_d;
   logic signed [DATA_W-1:0]   w_out_q, w_out_d;
   logic signed [DATA_W-1:0]   x_out_q, x_out_d;
   logic                       x_vout_q, x_vout_d;
   logic signed [ACC_W-1:0]    res_q, res_d;
   logic                       res_vld_q, res_vld_d;
   logic                       ovf_q, ovf_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d;

   logic signed [DATA_W-1:0]   b_op;
   logic                       m_valid, m_mode;
   logic signed [2*DATA_W-1:0] m_prod;
   logic signed [ACC_W-1:0]    m_side;
   logic signed [ACC_W-1:0]    prod_ext;
   pe_add_t                    ws_add, os_add;
   logic                       unused_hi;

   // Stationary weight is read before this cycle's w_load lands.
   assign b_op = (bus.mode == PE_MODE_OS) ? bus.w_in : w_stat_q;

   pe_mul_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) u_mul (
      .clk(clk), .rst_n(rst_n), .en(en),
      .valid_i(bus.x_valid_in), .mode_i(bus.mode),
      .a_i(bus.x_in), .b_i(b_op), .side_i(bus.acc_in),
      .valid_o(m_valid), .mode_o(m_mode), .prod_o(m_prod), .side_o(m_side)
   );

   assign prod_ext  = ACC_W'(m_prod);
   assign unused_hi = ^{ws_add.sum[PE_SUM_W-1:ACC_W], os_add.sum[PE_SUM_W-1:ACC_W]};

   always_comb begin
      w_stat_d  = bus.w_load ? bus.w_in : w_stat_q;
      w_out_d   = bus.w_in;
      x_out_d   = bus.x_in;
      x_vout_d  = bus.x_valid_in;
      res_d     = res_q;
      res_vld_d = 1'b0;
      ovf_d     = ovf_q;
      acc_d     = acc_q;
      ws_add    = sat_add(64'(m_side), 64'(prod_ext), ACC_W);
      os_add    = sat_add(64'(acc_q), 64'(prod_ext), ACC_W);
      // A WS result owns the output port; a drain in that same cycle is not honoured.
      if (m_valid && m_mode == PE_MODE_WS) begin
         res_d     = ws_add.sum[ACC_W-1:0];
         res_vld_d = 1'b1;
         ovf_d     = ovf_q | ws_add.ovf;
      end else begin
         if (m_valid) begin
            acc_d = os_add.sum[ACC_W-1:0];
            ovf_d = ovf_q | os_add.ovf;
         end
         if (bus.drain) begin
            res_d     = acc_d;
            res_vld_d = 1'b1;
            acc_d     = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_stat_q  <= '0;
         w_out_q   <= '0;
         x_out_q   <= '0;
         x_vout_q  <= 1'b0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
         acc_q     <= '0;
      end else if (en) begin
         w_stat_q  <= w_stat_d;
         w_out_q   <= w_out_d;
         x_out_q   <= x_out_d;
         x_vout_q  <= x_vout_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         ovf_q     <= ovf_d;
         acc_q     <= acc_d;
      end
   end

   assign bus.w_out       = w_out_q;
   assign bus.x_out       = x_out_q;
   assign bus.x_valid_out = x_vout_q;
   assign bus.res         = res_q;
   assign bus.res_valid   = res_vld_q;
   assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_pe_mac_sys.sv
// Scoreboard bench for pe_mac_sys: directed scenarios plus randomized traffic
// against a queue-based arithmetic reference model.
`timescale 1ns/1ps
module tb_pe_mac_sys;
   localparam int DATA_W  = 16;
   localparam int ACC_W   = 40;
   localparam int MUL_LAT = 2;
   localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
   localparam longint ACC_MIN = -ACC_MAX - 1;
   localparam longint ACC_MOD = longint'(1) <<< ACC_W;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   pe_mac_sys_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

   pe_mac_sys #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct { longint land; bit mode; longint prod; longint acc; } op_t;
   typedef struct { longint edge_n; longint val; } exp_t;

   op_t    pend[$];
   exp_t   expq[$];
   longint edge_no;
   longint os_acc;
   bit     m_ovf;
   int     w_stat;
   int     n_cmp = 0;
   int     n_bad = 0;

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic longint acc_add(input longint a, input longint b);
      longint s;
      s = a + b;
      if (s > ACC_MAX || s < ACC_MIN) begin
         m_ovf = 1'b1;
`ifdef PE_MAC_SAT_EN
         s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
         s = (s > ACC_MAX) ? s - ACC_MOD : s + ACC_MOD;
`endif
      end
      return s;
   endfunction

   // Reference model for one enabled clock edge with the given inputs.
   task automatic model_edge(input bit v, input bit m, input int x, input int w,
                             input bit wl, input longint acc, input bit dr);
      op_t op;
      edge_no++;
      if (v) pend.push_back('{edge_no + MUL_LAT, m, longint'(x) * longint'(m ? w : w_stat), acc});
      if (wl) w_stat = w;
      if (pend.size() > 0 && pend[0].land == edge_no) begin
         op = pend.pop_front();
         if (!op.mode) expq.push_back('{edge_no, acc_add(op.acc, op.prod)});
         else          os_acc = acc_add(os_acc, op.prod);
      end
      if (dr) begin
         expq.push_back('{edge_no, os_acc});
         os_acc = 0;
      end
   endtask

   task automatic cyc(input bit e, input bit v, input bit m, input int x, input int w,
                      input bit wl, input longint acc, input bit dr);
      @(negedge clk);
      en             = e;
      bus.x_valid_in = v;
      bus.mode       = m;
      bus.x_in       = DATA_W'(x);
      bus.w_in       = DATA_W'(w);
      bus.w_load     = wl;
      bus.acc_in     = ACC_W'(acc);
      bus.drain      = dr;
      if (e && rst_n) model_edge(v, m, x, w, wl, acc, dr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en = 1'b0; bus.x_valid_in = 1'b0; bus.mode = 1'b0; bus.x_in = '0; bus.w_in = '0;
      bus.w_load = 1'b0; bus.acc_in = '0; bus.drain = 1'b0;
      pend.delete(); expq.delete();
      os_acc = 0; m_ovf = 1'b0; w_stat = 0; edge_no = 0;
      #1;
      chk("reset_res", longint'(bus.res), 0);
      chk("reset_res_valid", longint'(bus.res_valid), 0);
      chk("reset_ovf", longint'(bus.ovf), 0);
      chk("reset_x_out", longint'(bus.x_out), 0);
      chk("reset_w_out", longint'(bus.w_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compares outputs just after every rising edge.
   initial begin : monitor
      longint mon_edge;
      longint last_res;
      bit     exp_rv, exv, e_s;
      int     ex, ew;
      exp_t   hit;
      mon_edge = 0; last_res = 0; exp_rv = 1'b0; exv = 1'b0; ex = 0; ew = 0;
      forever begin
         @(posedge clk);
         e_s = en && rst_n;
         if (!rst_n) begin
            mon_edge = 0; last_res = 0; exp_rv = 1'b0; exv = 1'b0; ex = 0; ew = 0;
         end else if (en) begin
            mon_edge++;
            ex     = int'(bus.x_in);
            ew     = int'(bus.w_in);
            exv    = bus.x_valid_in;
            exp_rv = (expq.size() > 0) && (expq[0].edge_n == mon_edge);
         end
         #1;
         if (!rst_n) continue;
         chk("res_valid", longint'(bus.res_valid), longint'(exp_rv));
         if (e_s && exp_rv) begin
            hit      = expq.pop_front();
            last_res = hit.val;
         end
         if (exp_rv) chk("res", longint'(bus.res), last_res);
         chk("ovf", longint'(bus.ovf), longint'(m_ovf));
         chk("x_out", longint'(bus.x_out), longint'(ex));
         chk("x_valid_out", longint'(bus.x_valid_out), longint'(exv));
         chk("w_out", longint'(bus.w_out), longint'(ew));
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit     e, v, m, wl, dr, ws_next;
      int     x, w;
      longint acc;
      rst_n = 1'b0;
      en = 1'b0; bus.x_valid_in = 1'b0; bus.mode = 1'b0; bus.x_in = '0; bus.w_in = '0;
      bus.w_load = 1'b0; bus.acc_in = '0; bus.drain = 1'b0;
      do_reset();

      // WS basic: weight 3, x=5, acc=10 -> 25
      cyc(1, 0, 0, 0, 3, 1, 0, 0);
      cyc(1, 1, 0, 5, 0, 0, 10, 0);
      idle(4);
      // WS signed, back to back -> -12, 20
      cyc(1, 1, 0, -4, 0, 0, 0, 0);
      cyc(1, 1, 0, 7, 0, 0, -1, 0);
      idle(4);
      // Weight collision -> 6 then 18
      cyc(1, 1, 0, 2, 9, 1, 0, 0);
      cyc(1, 1, 0, 2, 0, 0, 0, 0);
      idle(4);
      // OS accumulate 1..4 with w=2, drain aligned with last product -> 20, then 0
      for (int k = 1; k <= 4; k++) cyc(1, 1, 1, k, 2, 0, 0, 0);
      idle(1);
      cyc(1, 0, 1, 0, 0, 0, 0, 1);
      idle(1);
      cyc(1, 0, 1, 0, 0, 0, 0, 1);
      idle(3);
      // Stall during flight and while a result is being held
      cyc(1, 0, 0, 0, 3, 1, 0, 0);
      cyc(1, 1, 0, 5, 0, 0, 0, 0);
      cyc(0, 1, 1, 77, 88, 1, 123, 1);
      cyc(0, 1, 1, 77, 88, 1, 123, 1);
      idle(2);
      cyc(0, 1, 0, 11, 22, 1, 33, 1);
      cyc(0, 1, 0, 11, 22, 1, 33, 1);
      idle(3);
      // Overflow at the positive limit
      cyc(1, 0, 0, 0, 1, 1, 0, 0);
      cyc(1, 1, 0, 1, 0, 0, ACC_MAX, 0);
      idle(4);
      // Reset with an operand in flight
      cyc(1, 1, 0, 3, 0, 0, 100, 0);
      do_reset();
      idle(5);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         e  = ($urandom_range(9) != 0);
         v  = ($urandom_range(9) < 7);
         m  = 1'($urandom_range(1));
         x  = int'($signed(16'($urandom)));
         w  = int'($signed(16'($urandom)));
         wl = ($urandom_range(4) == 0);
         acc = ($urandom_range(19) == 0) ? ACC_MAX - longint'($urandom_range(1000))
                                         : longint'($signed(32'($urandom)));
         ws_next = (pend.size() > 0) && (pend[0].land == edge_no + 1) && !pend[0].mode;
         dr = ($urandom_range(7) == 0) && !ws_next;
         cyc(e, v, m, x, w, wl, acc, dr);
      end
      idle(6);
      @(negedge clk);
      chk("results_outstanding", longint'(expq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pe_mac_sys.md
Name: pe_mac_sys

Overview:
- Parametrised systolic-array processing element: signed integer multiply-accumulate, pipelined, with valid tracking, stall and two dataflow modes.
- Weight-stationary (WS): adds product to partial sum arriving from the neighbour.
- Output-stationary (OS): accumulates locally, drains on request.
- Tiled in a 2-D grid: x forwarded east, weight forwarded south, result forwarded south (WS) or drained (OS).

Parameters:
- DATA_W, 16, width of x and w operands (signed two's complement).
- ACC_W, 40, width of accumulator, acc_in and res (signed); must be >= 2*DATA_W.
- MUL_LAT, 2, multiplier pipeline stages (>=1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global advance; 0 freezes every register in the block.
- mode  in  1  0 = WS, 1 = OS; sampled with each valid operand.
- w_in  in  DATA_W  weight (WS preload) or streamed weight (OS).
- w_load  in  1  WS: capture w_in into stationary weight register.
- w_out  out  DATA_W  w_in registered one cycle, when en=1.
- x_in  in  DATA_W  activation.
- x_valid_in  in  1  x_in (and acc_in in WS) valid.
- x_out  out  DATA_W  x_in registered one cycle.
- x_valid_out  out  1  x_valid_in registered one cycle.
- acc_in  in  ACC_W  partial sum from neighbour (WS only).
- drain  in  1  OS: emit local accumulator and clear it.
- res  out  ACC_W  result.
- res_valid  out  1  res valid for one enabled cycle.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async, rst_n=0): res, w_out, x_out, stationary weight, OS accumulator, all pipeline data = 0; res_valid, x_valid_out, ovf, all pipeline valids = 0. Reset mid-operation discards in-flight operands.
- en=0: no register changes; outputs hold; res_valid holds its value, but a held res_valid does not count as a new result.
- Forwarding: x_out/x_valid_out/w_out are 1-cycle registered copies (w_out independent of w_load).
- Multiplier operand: WS uses the stationary weight; OS uses w_in. w_load and x_valid_in in the same cycle: the product uses the OLD weight; the new weight applies from the next cycle.
- Product is full 2*DATA_W signed, sign-extended to ACC_W.
- Pipeline: operand, mode and acc_in enter a MUL_LAT-deep pipeline with valid bit. acc_in is delayed alongside the product.
- Add stage: one further register. Total latency MUL_LAT+1 enabled cycles from x_valid_in to result.
- WS: res = acc_in + x*w; res_valid=1.
- OS:
  - acc_local += x*w; no res_valid.
  - drain=1 at the add stage: res = acc_local including any product landing that cycle; res_valid=1; acc_local <= 0.
  - Drain with an empty pipeline emits the current acc_local.
- Mode is carried per operand, so a mode switch with operands in flight is legal and each operand completes in its own mode.
- Overflow: signed ACC_W addition overflow sets ovf; ovf stays set until reset. Result handling is per Optional Feature.

Optional Feature:
- Macro: PE_MAC_SAT_EN.
- Defined: on overflow, result clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1). Applies to WS res and to the OS accumulator.
- Undefined: two's-complement wrap.
- ovf is set on overflow in both cases.

Decomposition:
- Package pe_pkg holds:
  - mode constants PE_MODE_WS=0, PE_MODE_OS=1;
  - function sat_add(a,b,acc_w) returning sum and overflow bit.
- Sub-module pe_mul_pipe: DATA_W x DATA_W signed multiplier with MUL_LAT register stages.
  - Carries valid, mode and a sideband of ACC_W bits (acc_in).
  - Shares en and rst_n with the parent.

Test Plan (DATA_W=16, ACC_W=40, MUL_LAT=2):
- WS basic: w_load w_in=3; next cycle x=5, acc_in=10, valid -> res=25, res_valid=1 exactly 3 cycles later; x_out=5 after 1 cycle.
- WS signed/back-to-back: w=3; x=-4,acc=0 then x=7,acc=-1 on consecutive cycles -> res=-12 then 20 on consecutive cycles.
- WS weight collision: w=3 loaded; then w_load w_in=9 together with x=2 -> res=6; next x=2 -> res=18.
- OS accumulate/drain: mode=1, w_in=2, x=1,2,3,4 on consecutive cycles, drain aligned with the last product -> single res=20, res_valid=1; second drain -> res=0.
- Stall: en=0 for 2 cycles after issuing x=5,w=3,acc=0 -> res=15 arrives 5 clock edges after issue; outputs frozen during stall.
- Overflow/reset: acc_in=2^39-1, x=1, w=1 -> with PE_MAC_SAT_EN res=2^39-1, without res=-2^39; ovf=1 in both. Assert rst_n=0 mid-pipeline -> res=0, res_valid=0, ovf=0 immediately; no stale result after release.
